// File: rtl/bsg_trace_replay_multi.sv
// Multi-channel trace replay engine: walks a ROM of {op, chan, payload}
// words, driving and checking valid/ready channels. Supports counted
// loops, cycle delays, and sticky first-error address capture.
module bsg_trace_replay_multi #(
  parameter int payload_width_p  = 80,
  parameter int num_channels_p   = 4,
  parameter int rom_addr_width_p = 8,
  parameter int counter_width_p  = (payload_width_p < 16) ? payload_width_p : 16,
  localparam int chan_width_lp   = (num_channels_p > 1) ? $clog2(num_channels_p) : 1,
  localparam int rom_width_lp    = 4 + chan_width_lp + payload_width_p
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      en_i,
  input  logic [num_channels_p-1:0]                 v_i,
  input  logic [num_channels_p*payload_width_p-1:0] data_i,
  output logic [num_channels_p-1:0]                 ready_and_o,
  output logic [num_channels_p-1:0]                 v_o,
  output logic [payload_width_p-1:0]                data_o,
  input  logic [num_channels_p-1:0]                 yumi_i,
  output logic [rom_addr_width_p-1:0]               rom_addr_o,
  input  logic [rom_width_lp-1:0]                   rom_data_i,
  output logic                                      done_o,
  output logic                                      error_o,
  output logic [rom_addr_width_p-1:0]               error_addr_o
);

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_SEND       = 4'd1;
  localparam logic [3:0] OP_RECV       = 4'd2;
  localparam logic [3:0] OP_DONE       = 4'd3;
  localparam logic [3:0] OP_FINISH     = 4'd4;
  localparam logic [3:0] OP_CYCLE_DEC  = 4'd5;
  localparam logic [3:0] OP_CYCLE_INIT = 4'd6;
  localparam logic [3:0] OP_LOOP_INIT  = 4'd7;
  localparam logic [3:0] OP_LOOP_BR    = 4'd8;

  localparam logic [chan_width_lp:0] num_chan_lp = (chan_width_lp+1)'(num_channels_p);

  logic [rom_addr_width_p-1:0] addr_r, error_addr_r, next_addr;
  logic                        done_r, error_r, done_n;
  logic [counter_width_p-1:0]  cycle_ctr_r, loop_ctr_r, cycle_ctr_n, loop_ctr_n;

  logic [3:0]                  op;
  logic [chan_width_lp-1:0]    chan;
  logic [payload_width_p-1:0]  payload;
  logic                        exec, chan_ok, complete, err;
  logic [num_channels_p-1:0]   sel, send_v, recv_rdy;
  logic [payload_width_p-1:0]  recv_data;

  assign op      = rom_data_i[rom_width_lp-1 -: 4];
  assign chan    = rom_data_i[payload_width_p +: chan_width_lp];
  assign payload = rom_data_i[payload_width_p-1:0];
  assign exec    = en_i && !done_r && !reset_i;
  assign chan_ok = ({1'b0, chan} < num_chan_lp);

  // One-hot channel select and the selected channel's input payload
  always_comb begin
    sel       = '0;
    recv_data = '0;
    for (int k = 0; k < num_channels_p; k++) begin
      sel[k] = chan_ok && (chan == chan_width_lp'(k));
      if (sel[k]) recv_data = data_i[k*payload_width_p +: payload_width_p];
    end
  end

  // Instruction decode: completion, handshakes, next state and error detection
  always_comb begin
    complete    = 1'b0;
    err         = 1'b0;
    next_addr   = addr_r + 1'b1;
    send_v      = '0;
    recv_rdy    = '0;
    cycle_ctr_n = cycle_ctr_r;
    loop_ctr_n  = loop_ctr_r;
    done_n      = done_r;
    if (exec) begin
      case (op)
        OP_NOP: complete = 1'b1;
        OP_SEND: begin
          if (!chan_ok) begin
            complete = 1'b1;
            err      = 1'b1;
          end else begin
            send_v   = sel;
            complete = |(yumi_i & sel);
          end
        end
        OP_RECV: begin
          if (!chan_ok) begin
            complete = 1'b1;
            err      = 1'b1;
          end else begin
            recv_rdy = sel;
            complete = |(v_i & sel);
            err      = complete && (recv_data != payload);
          end
        end
        // FINISH behaves as DONE in hardware
        OP_DONE, OP_FINISH: begin
          complete = 1'b1;
          done_n   = 1'b1;
        end
        OP_CYCLE_DEC: begin
          if (cycle_ctr_r == '0) complete = 1'b1;
          else cycle_ctr_n = cycle_ctr_r - 1'b1;
        end
        OP_CYCLE_INIT: begin
          cycle_ctr_n = payload[counter_width_p-1:0];
          complete    = 1'b1;
        end
        OP_LOOP_INIT: begin
          loop_ctr_n = payload[counter_width_p-1:0];
          complete   = 1'b1;
        end
        OP_LOOP_BR: begin
          complete = 1'b1;
          if (loop_ctr_r != '0) begin
            loop_ctr_n = loop_ctr_r - 1'b1;
            next_addr  = payload[rom_addr_width_p-1:0];
          end
        end
        default: begin
          complete = 1'b1;
          err      = 1'b1;
        end
      endcase
    end
  end

  // Architectural state; error address latches only on the first error
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r       <= '0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      error_addr_r <= '0;
      cycle_ctr_r  <= '0;
      loop_ctr_r   <= '0;
    end else begin
      if (complete) addr_r <= next_addr;
      done_r      <= done_n;
      cycle_ctr_r <= cycle_ctr_n;
      loop_ctr_r  <= loop_ctr_n;
      if (err && !error_r) begin
        error_r      <= 1'b1;
        error_addr_r <= addr_r;
      end
    end
  end

  // Once done, every input is drained; disable or reset forces handshakes low
  assign ready_and_o  = (done_r && en_i && !reset_i) ? {num_channels_p{1'b1}} : recv_rdy;
  assign v_o          = send_v;
  assign data_o       = payload;
  assign rom_addr_o   = addr_r;
  assign done_o       = done_r;
  assign error_o      = error_r;
  assign error_addr_o = error_addr_r;

endmodule

// File: tb/tb_bsg_trace_replay_multi.sv
// Directed bench for bsg_trace_replay_multi: a 4-channel instance for the
// main scenarios and a 3-channel instance for out-of-range channel errors.
module tb_bsg_trace_replay_multi;

  logic        clk = 1'b0;
  logic        reset_i, en_i;
  logic [3:0]  v_i, yumi_i, ready_and_o, v_o;
  logic [63:0] data_i;
  logic [15:0] data_o;
  logic [7:0]  rom_addr, error_addr;
  logic [21:0] rom_data;
  logic        done_o, error_o;
  logic [21:0] rom [0:255];

  logic [2:0]  ready2, v2;
  logic [15:0] data2;
  logic [7:0]  rom_addr2, error_addr2;
  logic [21:0] rom_data2;
  logic        done2, error2;
  logic [21:0] rom2 [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = rom2[rom_addr2];

  bsg_trace_replay_multi #(.payload_width_p(16), .num_channels_p(4), .rom_addr_width_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(v_i), .data_i(data_i),
    .ready_and_o(ready_and_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .done_o(done_o),
    .error_o(error_o), .error_addr_o(error_addr)
  );

  bsg_trace_replay_multi #(.payload_width_p(16), .num_channels_p(3), .rom_addr_width_p(8)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .v_i(3'b000), .data_i(48'h0),
    .ready_and_o(ready2), .v_o(v2), .data_o(data2), .yumi_i(3'b111),
    .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .done_o(done2),
    .error_o(error2), .error_addr_o(error_addr2)
  );

  function automatic logic [21:0] w(input logic [3:0] op, input logic [1:0] ch, input logic [15:0] pl);
    return {op, ch, pl};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    en_i    = 1'b0;
    v_i     = '0;
    yumi_i  = '0;
    data_i  = '0;
    for (int i = 0; i < 256; i++) begin
      rom[i]  = '0;
      rom2[i] = '0;
    end
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_i = 1'b0;
    en_i    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sends, cyc;

    // Reset state
    do_reset();
    en_i = 1'b1;
    #1;
    check_eq("rst_v_o", v_o, 4'b0000);
    check_eq("rst_ready", ready_and_o, 4'b0000);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_error", error_o, 1'b0);
    check_eq("rst_addr", rom_addr, 8'd0);
    check_eq("rst_err_addr", error_addr, 8'd0);

    // SEND ch2 with yumi withheld, foreign yumi on ch0 ignored
    do_reset();
    rom[0] = w(4'd1, 2'd2, 16'hBEEF);
    rom[1] = w(4'd3, 2'd0, 16'h0000);
    release_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      yumi_i    = '0;
      yumi_i[2] = (k == 3);
      yumi_i[0] = (k == 1);
      #1;
      check_eq($sformatf("send_v_o_%0d", k), v_o, 4'b0100);
      check_eq($sformatf("send_addr_%0d", k), rom_addr, 8'd0);
    end
    check_eq("send_data", data_o, 16'hBEEF);
    tick();
    yumi_i = '0;
    #1;
    check_eq("send_adv", rom_addr, 8'd1);
    check_eq("send_vo_after", v_o, 4'b0000);
    tick();
    check_eq("send_done", done_o, 1'b1);
    check_eq("send_drain", ready_and_o, 4'b1111);
    check_eq("send_addr_done", rom_addr, 8'd2);

    // RECV pass, RECV mismatch, later mismatch keeps first error address
    do_reset();
    rom[0] = w(4'd2, 2'd1, 16'h1234);
    rom[1] = w(4'd2, 2'd3, 16'h00FF);
    rom[5] = w(4'd2, 2'd0, 16'hAAAA);
    rom[6] = w(4'd3, 2'd0, 16'h0000);
    release_reset();
    v_i = 4'b0010;
    data_i[16 +: 16] = 16'h1234;
    #1;
    check_eq("recv0_ready", ready_and_o, 4'b0010);
    tick();
    check_eq("recv0_addr", rom_addr, 8'd1);
    check_eq("recv0_err", error_o, 1'b0);
    v_i = 4'b1000;
    data_i[48 +: 16] = 16'h00FE;
    #1;
    check_eq("recv1_ready", ready_and_o, 4'b1000);
    tick();
    v_i = '0;
    check_eq("recv1_err", error_o, 1'b1);
    check_eq("recv1_err_addr", error_addr, 8'd1);
    tick(); tick(); tick();
    check_eq("recv5_addr", rom_addr, 8'd5);
    v_i = 4'b0001;
    data_i[0 +: 16] = 16'h5555;
    tick();
    v_i = '0;
    check_eq("recv5_adv", rom_addr, 8'd6);
    check_eq("recv5_err", error_o, 1'b1);
    check_eq("recv5_err_addr", error_addr, 8'd1);

    // Counted loop: body runs init+1 times
    do_reset();
    rom[0] = w(4'd7, 2'd0, 16'd2);
    rom[1] = w(4'd1, 2'd0, 16'h0042);
    rom[2] = w(4'd8, 2'd0, 16'd1);
    rom[3] = w(4'd3, 2'd0, 16'h0000);
    release_reset();
    yumi_i = 4'b0001;
    #1;
    sends = 0;
    cyc   = 0;
    while (!done_o && cyc < 50) begin
      if (v_o[0]) sends++;
      tick();
      cyc++;
    end
    yumi_i = '0;
    #1;
    check_eq("loop_sends", sends, 3);
    check_eq("loop_cycles", cyc, 8);
    check_eq("loop_done", done_o, 1'b1);
    check_eq("loop_drain", ready_and_o, 4'b1111);
    check_eq("loop_addr", rom_addr, 8'd4);

    // Cycle delay: CYCLE_INIT 3 then CYCLE_DEC spends 4 cycles
    do_reset();
    rom[0] = w(4'd6, 2'd0, 16'd3);
    rom[1] = w(4'd5, 2'd0, 16'd0);
    rom[2] = w(4'd3, 2'd0, 16'd0);
    release_reset();
    #1;
    cyc = 0;
    while (rom_addr != 8'd2 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("cyc_latency", cyc, 5);
    check_eq("cyc_ctr_zero", dut.cycle_ctr_r, 16'd0);
    tick();
    check_eq("cyc_done", done_o, 1'b1);

    // Illegal op and out-of-range channel on the 3-channel build
    do_reset();
    rom2[0] = w(4'hA, 2'd0, 16'h0000);
    rom2[1] = w(4'd1, 2'd3, 16'h1111);
    rom2[2] = w(4'd3, 2'd0, 16'h0000);
    release_reset();
    #1;
    check_eq("ill_v_o", v2, 3'b000);
    check_eq("ill_err_pre", error2, 1'b0);
    tick();
    check_eq("ill_addr", rom_addr2, 8'd1);
    check_eq("ill_err", error2, 1'b1);
    check_eq("ill_err_addr", error_addr2, 8'd0);
    check_eq("oor_v_o", v2, 3'b000);
    tick();
    check_eq("oor_addr", rom_addr2, 8'd2);
    check_eq("oor_err_addr", error_addr2, 8'd0);
    tick();
    check_eq("oor_done", done2, 1'b1);

    // Asynchronous reset mid-SEND
    do_reset();
    rom[0] = w(4'd0, 2'd0, 16'h0000);
    rom[1] = w(4'd1, 2'd1, 16'hCAFE);
    release_reset();
    #1;
    tick();
    check_eq("ar_v_o_pre", v_o, 4'b0010);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("ar_v_o_async", v_o, 4'b0000);
    check_eq("ar_addr_async", rom_addr, 8'd0);
    @(negedge clk);
    reset_i = 1'b0;
    en_i    = 1'b0;
    #1;
    check_eq("ar_addr_post", rom_addr, 8'd0);
    check_eq("ar_done_post", done_o, 1'b0);

    // en_i low freezes a SEND; it resumes when enabled
    do_reset();
    rom[0] = w(4'd1, 2'd3, 16'h7777);
    release_reset();
    en_i   = 1'b0;
    yumi_i = 4'b1000;
    #1;
    check_eq("en_v_o_off", v_o, 4'b0000);
    tick();
    check_eq("en_addr_hold", rom_addr, 8'd0);
    en_i = 1'b1;
    #1;
    check_eq("en_v_o_on", v_o, 4'b1000);
    tick();
    check_eq("en_addr_adv", rom_addr, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
